uart_tx_arbiter: RTL

- Shares the single byte-write interface of the UART transmitter (8-bit data plus write-enable, gated by the FIFO-full status) between N_REQ independent byte sources, e.g. the AHB UART register slave and a debug/log engine.
- Grants are message-atomic: once granted, a requester owns the transmitter until it flags the last byte or hits the burst limit.
- Round-robin between messages.
- Sits between the requesters and the UART transmitter, in the clk domain.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit-path blocks: arbiter state encoding,
// the UART byte width and default limits for burst length and stall timeout.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int UART_BYTE_W   = 8;
  localparam int MAX_BURST_DEF = 16;
  localparam int TIMEOUT_DEF   = 255;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first set request
// found searching upward from ptr+1, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  // Walk from the farthest candidate to the nearest so the nearest set
  // request is the last one written and therefore wins.
  always_comb begin
    gnt = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      int idx;
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) gnt = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing the UART transmitter byte-write
// port between N_REQ sources. Optional stall timeout: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         RSTn,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             grant,
  output logic                         busy,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic                         tx_en,
  input  logic                         tx_full,
  output logic                         timeout_evt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 0 || MAX_BURST > 255 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of legal range");
  end

  arb_state_e       state_reg;
  logic [N_REQ-1:0] grant_reg;
  logic [PTR_W-1:0] rr_ptr_reg;
  logic [7:0]       burst_cnt_reg;

  logic [N_REQ-1:0]       pick_gnt;
  logic [PTR_W-1:0]       owner_idx;
  logic                   owner_valid;
  logic                   owner_last;
  logic                   xfer;
  logic                   burst_hit;
  logic                   timeout_hit;
  logic                   release_now;
  logic [UART_BYTE_W-1:0] masked [N_REQ];

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .gnt (pick_gnt)
  );

  // A full FIFO blocks the handshake in the same cycle, so tx_en never meets tx_full.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign req_ready[gi] = grant_reg[gi] & ~tx_full;
    assign masked[gi]    = req_data[gi*UART_BYTE_W +: UART_BYTE_W] &
                           {UART_BYTE_W{grant_reg[gi]}};
  end

  always_comb begin
    tx_data   = '0;
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      tx_data = tx_data | masked[i];
      if (grant_reg[i]) owner_idx = PTR_W'(i);
    end
  end

  assign owner_valid = |(req_valid & grant_reg);
  assign owner_last  = |(req_last & grant_reg);
  assign xfer        = owner_valid & ~tx_full;
  assign tx_en       = xfer;
  assign grant       = grant_reg;
  assign busy        = (state_reg == ST_LOCK);
  assign burst_hit   = (MAX_BURST != 0) && (burst_cnt_reg == 8'(MAX_BURST - 1));
  assign release_now = (state_reg == ST_LOCK) &&
                       ((xfer && (owner_last || burst_hit)) || timeout_hit);

`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0] idle_cnt_reg;
  logic       timeout_evt_reg;

  assign timeout_hit = (state_reg == ST_LOCK) && !owner_valid &&
                       (idle_cnt_reg == 8'(TIMEOUT - 1));
  assign timeout_evt = timeout_evt_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= PTR_W'(N_REQ - 1);
      burst_cnt_reg <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_reg    <= '0;
      timeout_evt_reg <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_evt_reg <= timeout_hit;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            state_reg     <= ST_LOCK;
            grant_reg     <= pick_gnt;
            burst_cnt_reg <= '0;
          end
        end
        ST_LOCK: begin
          if (release_now) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= owner_idx;
            burst_cnt_reg <= '0;
          end else if (xfer) begin
            burst_cnt_reg <= burst_cnt_reg + 8'd1;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Back-pressure keeps valid high, so a full FIFO never counts as idle.
          if (owner_valid || release_now) idle_cnt_reg <= '0;
          else                            idle_cnt_reg <= idle_cnt_reg + 8'd1;
`endif
        end
      endcase
    end
  end

endmodule
